// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: state encoding, byte width and the underrun fill byte.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = 3;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam spi_byte_t SPI_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sync_ff.sv
// Depth-parametrised flop synchroniser for one asynchronous input, with a chosen reset value.
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises CS/SCK/MOSI into clk and exchanges bytes with the CPU
// through single-byte TX/RX holding registers with sticky overrun/underrun flags.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  spi_cs_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_read,
    input  logic                  clr_status,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  txn_active
);

    logic w_cs_s, w_sck_s, w_mosi_s;

    // CS resets low so a CS held low through reset never looks like a falling edge.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rstn(rstn), .i_d(spi_cs_n), .o_q(w_cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .i_d(spi_sck), .o_q(w_sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .i_d(spi_mosi), .o_q(w_mosi_s)
    );

    logic [0:0]            r_state, w_state_nxt;
    logic                  r_cs_d, r_sck_d;
    logic [SPI_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    spi_byte_t             r_tx_sr, w_tx_sr_nxt;
    logic [SPI_BYTE_W-2:0] r_rx_sr, w_rx_sr_nxt;
    spi_byte_t             r_tx_hold, w_tx_hold_nxt;
    logic                  r_tx_empty, w_tx_empty_nxt;
    spi_byte_t             r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  r_underrun, w_underrun_nxt;
    logic                  r_miso_oe, w_miso_oe_nxt;
    logic                  w_reload;
    spi_byte_t             w_rx_byte;

    logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    assign w_cs_fall  =  r_cs_d  & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_d  &  w_cs_s;
    assign w_sck_rise = ~r_sck_d &  w_sck_s;
    assign w_sck_fall =  r_sck_d & ~w_sck_s;
    assign w_rx_byte  = {r_rx_sr, w_mosi_s};

    // Next-state and datapath update; CPU strobes apply first so bus events can override them.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_tx_hold_nxt  = r_tx_hold;
        w_tx_empty_nxt = r_tx_empty;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = r_rx_valid;
        w_overrun_nxt  = r_overrun;
        w_underrun_nxt = r_underrun;
        w_miso_oe_nxt  = r_miso_oe;
        w_reload       = 1'b0;

        if (clr_status) begin
            w_overrun_nxt  = 1'b0;
            w_underrun_nxt = 1'b0;
        end
        if (rx_read) begin
            w_rx_valid_nxt = 1'b0;
        end
        if (tx_load && r_tx_empty) begin
            w_tx_hold_nxt  = tx_data;
            w_tx_empty_nxt = 1'b0;
        end

        if (w_cs_rise) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_rx_sr_nxt   = '0;
            w_tx_sr_nxt   = SPI_FILL_BYTE;
            w_miso_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt   = ST_SHIFT;
                        w_bit_cnt_nxt = '0;
                        w_miso_oe_nxt = 1'b1;
                        w_reload      = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_sck_rise) begin
                        w_rx_sr_nxt   = w_rx_byte[SPI_BYTE_W-2:0];
                        w_bit_cnt_nxt = r_bit_cnt + SPI_CNT_W'(1);
                        if (r_bit_cnt == SPI_CNT_W'(7)) begin
                            if (!r_rx_valid || rx_read) begin
                                w_rx_data_nxt  = w_rx_byte;
                                w_rx_valid_nxt = 1'b1;
                            end else begin
                                w_overrun_nxt  = 1'b1;
                            end
                        end
                    end else if (w_sck_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_reload = 1'b1;
                        end else begin
                            w_tx_sr_nxt = {r_tx_sr[SPI_BYTE_W-2:0], 1'b1};
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // A load in the same cycle as an empty reload is kept for the following byte.
        if (w_reload) begin
            if (!r_tx_empty) begin
                w_tx_sr_nxt    = r_tx_hold;
                w_tx_empty_nxt = 1'b1;
            end else begin
                w_tx_sr_nxt    = SPI_FILL_BYTE;
                w_underrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cs_d     <= 1'b0;
            r_sck_d    <= 1'b0;
            r_bit_cnt  <= '0;
            r_tx_sr    <= SPI_FILL_BYTE;
            r_rx_sr    <= '0;
            r_tx_hold  <= '0;
            r_tx_empty <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cs_d     <= w_cs_s;
            r_sck_d    <= w_sck_s;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_tx_hold  <= w_tx_hold_nxt;
            r_tx_empty <= w_tx_empty_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_overrun  <= w_overrun_nxt;
            r_underrun <= w_underrun_nxt;
            r_miso_oe  <= w_miso_oe_nxt;
        end
    end

    // MISO is the TX shift register MSB, which idles at 1 via the fill byte.
    assign spi_miso    = r_tx_sr[SPI_BYTE_W-1];
    assign spi_miso_oe = r_miso_oe;
    assign tx_empty    = r_tx_empty;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign overrun     = r_overrun;
    assign underrun    = r_underrun;
    assign txn_active  = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an SPI controller model drives transfers, a byte-level reference model
// predicts MISO bytes and CPU-visible registers, and monitors compare against scoreboards.
module tb_spi_target;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_read = 1'b0;
    logic       clr_status = 1'b0;
    logic       overrun, underrun, txn_active;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
        .clr_status(clr_status), .overrun(overrun), .underrun(underrun),
        .txn_active(txn_active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_miso[$];
    logic [7:0] exp_rx[$];

    // Byte-level reference model of the CPU-visible state.
    bit         m_full;
    logic [7:0] m_hold;
    bit         m_rx_valid;
    logic [7:0] m_rx_data;
    bit         m_over, m_under;
    logic [7:0] cur_exp;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_full = 0; m_hold = 8'h00; m_rx_valid = 0; m_rx_data = 8'h00;
        m_over = 0; m_under = 0; cur_exp = 8'hFF;
    endtask

    task automatic m_reload(output logic [7:0] b);
        if (m_full) begin
            b = m_hold;
            m_full = 0;
        end else begin
            b = 8'hFF;
            m_under = 1;
        end
    endtask

    task automatic m_load(input logic [7:0] d);
        if (!m_full) begin
            m_hold = d;
            m_full = 1;
        end
    endtask

    task automatic cpu_load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        m_load(d);
        check("tx_empty_after_load", 8'(tx_empty), 8'(!m_full));
    endtask

    task automatic cpu_read();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        m_rx_valid = 0;
        check("rx_valid_after_read", 8'(rx_valid), 8'd0);
    endtask

    task automatic cpu_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        m_over = 0;
        m_under = 0;
        check("overrun_after_clr", 8'(overrun), 8'd0);
        check("underrun_after_clr", 8'(underrun), 8'd0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rx_valid"}, 8'(rx_valid), 8'(m_rx_valid));
        check({tag, "_rx_data"}, rx_data, m_rx_data);
        check({tag, "_tx_empty"}, 8'(tx_empty), 8'(!m_full));
        check({tag, "_overrun"}, 8'(overrun), 8'(m_over));
        check({tag, "_underrun"}, 8'(underrun), 8'(m_under));
        check({tag, "_txn_active"}, 8'(txn_active), 8'd0);
        check({tag, "_miso_oe"}, 8'(spi_miso_oe), 8'd0);
        check({tag, "_miso"}, 8'(spi_miso), 8'd1);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        m_reload(cur_exp);
        repeat (4) tick();
        check("txn_active_start", 8'(txn_active), 8'd1);
        check("miso_oe_start", 8'(spi_miso_oe), 8'd1);
        check("miso_first_bit", 8'(spi_miso), 8'(cur_exp[7]));
    endtask

    task automatic cs_end();
        repeat (HALF) tick();
        spi_cs_n = 1'b1;
        repeat (HALF) tick();
        check_status("end");
    endtask

    // One byte (or a truncated byte when nbits < 8), with optional mid-byte CPU activity.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit do_load,
                            input logic [7:0] ld, input bit do_read, input bit coinc,
                            input bit chk_lat);
        if (nbits == 8) exp_miso.push_back(cur_exp);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (HALF) tick();
            spi_sck = 1'b1;
            for (int t = 1; t <= HALF; t++) begin
                tick();
                if (i == 7 && t == 2) begin
                    if (chk_lat) check("rx_valid_before_lat", 8'(rx_valid), 8'(m_rx_valid));
                    if (coinc) rx_read = 1'b1;
                    if (!m_rx_valid || coinc) begin
                        m_rx_valid = 1;
                        m_rx_data  = mo;
                        exp_rx.push_back(mo);
                    end else begin
                        m_over = 1;
                    end
                end
                if (i == 7 && t == 3) begin
                    rx_read = 1'b0;
                    if (chk_lat) begin
                        check("rx_valid_at_lat", 8'(rx_valid), 8'd1);
                        check("rx_data_at_lat", rx_data, m_rx_data);
                    end
                end
                if (i == 3 && t == 1 && do_load) begin
                    tx_data = ld;
                    tx_load = 1'b1;
                end
                if (i == 3 && t == 2 && do_load) begin
                    tx_load = 1'b0;
                    m_load(ld);
                    check("tx_empty_mid_load", 8'(tx_empty), 8'(!m_full));
                end
                if (i == 3 && t == 4 && do_read) rx_read = 1'b1;
                if (i == 3 && t == 5 && do_read) begin
                    rx_read = 1'b0;
                    m_rx_valid = 0;
                    check("rx_valid_mid_read", 8'(rx_valid), 8'd0);
                end
            end
            spi_sck = 1'b0;
            if (i == 7) m_reload(cur_exp);
        end
    endtask

    // MISO monitor: assembles bytes as the controller samples them on SCK rise.
    initial begin
        int         cnt;
        logic [7:0] sh;
        logic [7:0] e;
        cnt = 0;
        sh  = 8'h00;
        forever begin
            @(posedge spi_sck or posedge spi_cs_n);
            if (spi_cs_n) begin
                cnt = 0;
            end else begin
                sh = {sh[6:0], spi_miso};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (exp_miso.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL miso_byte: got %0h with no byte expected", sh);
                    end else begin
                        e = exp_miso.pop_front();
                        check("miso_byte", sh, e);
                    end
                end
            end
        end
    end

    // RX monitor: a byte is presented when rx_valid rises or stays set across a read.
    initial begin
        bit         pv, pr;
        logic [7:0] e;
        pv = 0;
        pr = 0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && (!pv || pr)) begin
                if (exp_rx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_byte: got %0h with no byte expected", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_byte", rx_data, e);
                end
            end
            pv = (rx_valid === 1'b1);
            pr = (rx_read === 1'b1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int nbits;
        m_reset();
        repeat (3) tick();
        check_status("reset");
        rstn = 1'b1;
        repeat (5) tick();

        // Single byte: A5 out, 3C in, with latency check.
        cpu_load(8'hA5);
        cs_begin();
        spi_byte(8'h3C, 8, 0, 8'h00, 0, 0, 1);
        cs_end();
        cpu_read();
        cpu_clr();

        // Two bytes with one loaded: second byte is the fill byte.
        cpu_load(8'h11);
        cs_begin();
        spi_byte(8'($urandom), 8, 0, 8'h00, 0, 0, 0);
        spi_byte(8'($urandom), 8, 0, 8'h00, 0, 0, 0);
        cs_end();
        check("underrun_set", 8'(underrun), 8'd1);
        cpu_clr();
        cpu_read();

        // Overrun, then the same pair with a read coinciding with the 8th bit.
        cs_begin();
        spi_byte(8'h01, 8, 0, 8'h00, 0, 0, 0);
        spi_byte(8'h02, 8, 0, 8'h00, 0, 0, 0);
        cs_end();
        check("overrun_kept_data", rx_data, 8'h01);
        cpu_clr();
        cpu_read();
        cs_begin();
        spi_byte(8'h01, 8, 0, 8'h00, 0, 0, 0);
        spi_byte(8'h02, 8, 0, 8'h00, 0, 1, 0);
        cs_end();
        check("coinc_read_data", rx_data, 8'h02);
        check("coinc_read_no_overrun", 8'(overrun), 8'd0);
        cpu_read();
        cpu_clr();

        // Abort after 5 bits, then a clean transfer.
        cpu_load(8'h96);
        cs_begin();
        spi_byte(8'($urandom), 5, 1, 8'h69, 0, 0, 0);
        cs_end();
        cs_begin();
        spi_byte(8'hC7, 8, 0, 8'h00, 0, 0, 1);
        cs_end();
        cpu_read();

        // Reset mid-byte with CS held low.
        cpu_load(8'h77);
        cs_begin();
        spi_byte(8'($urandom), 3, 0, 8'h00, 0, 0, 0);
        rstn = 1'b0;
        #1;
        m_reset();
        check_status("in_reset");
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        spi_byte(8'($urandom), 3, 0, 8'h00, 0, 0, 0);
        check("no_txn_after_reset", 8'(txn_active), 8'd0);
        check("no_oe_after_reset", 8'(spi_miso_oe), 8'd0);
        spi_cs_n = 1'b1;
        repeat (HALF) tick();
        check_status("after_reset");

        // Load while full is ignored.
        cpu_load(8'h5A);
        cpu_load(8'hC3);
        cs_begin();
        spi_byte(8'($urandom), 8, 0, 8'h00, 0, 0, 0);
        cs_end();
        cpu_clr();

        // Randomised transfers.
        for (int k = 0; k < 25; k++) begin
            nb = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) cpu_load(8'($urandom));
            cs_begin();
            for (int b = 0; b < nb; b++) begin
                nbits = 8;
                if (b == nb - 1 && $urandom_range(0, 5) == 0) nbits = $urandom_range(1, 7);
                spi_byte(8'($urandom), nbits, $urandom_range(0, 1) == 1, 8'($urandom),
                         $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 0);
            end
            cs_end();
            if ($urandom_range(0, 2) == 0) cpu_clr();
        end

        repeat (20) tick();
        check("miso_queue_drained", 8'(exp_miso.size()), 8'd0);
        check("rx_queue_drained", 8'(exp_rx.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (responder) for tinyQV peripheral space: the opposite end of the on-chip SPI controller. It lets an external SPI controller exchange bytes with the CPU. External CS/SCK/MOSI are synchronised into the `clk` domain. Received bytes and the next byte to transmit pass through single-byte holding registers with valid/empty flags, which the CPU reads and writes through memory-mapped peripheral registers.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on CS/SCK/MOSI; minimum 2.

Ports:
- `clk` in 1: single clock for all logic.
- `rstn` in 1: reset, asynchronous and active-low.
- `spi_cs_n` in 1: external chip select, active-low, asynchronous to `clk`.
- `spi_sck` in 1: external SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi` in 1: data from the external controller, MSB first.
- `spi_miso` out 1: data to the external controller, MSB first.
- `spi_miso_oe` out 1: high while selected.
- `tx_data` in 8: next byte to send.
- `tx_load` in 1: one-cycle write strobe for `tx_data`.
- `tx_empty` out 1: TX holding register can accept a byte.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` is unread.
- `rx_read` in 1: one-cycle strobe; CPU has consumed `rx_data`.
- `clr_status` in 1: one-cycle strobe; clears the sticky flags.
- `overrun` out 1: sticky; a byte was dropped because `rx_valid` was still set.
- `underrun` out 1: sticky; a byte started with TX empty.
- `txn_active` out 1: high while the block is in state SHIFT.

## Operation
- State machine with two states, IDLE and SHIFT, plus a 3-bit `bit_cnt`, a TX shift register and an RX shift register. All edge detection uses the synchronised signals.
- IDLE to SHIFT on a synchronised CS falling edge:
  - `bit_cnt` set to 0.
  - TX shift register loaded from the holding register if full, and `tx_empty` set to 1.
  - If the holding register is empty, load 8'hFF and set `underrun`.
  - `spi_miso` takes bit 7 of the TX shift register; `spi_miso_oe` goes to 1.
- SCK rising edge in SHIFT:
  - Shift the RX register left with the synchronised MOSI; increment `bit_cnt`, wrapping 7 to 0.
  - On the 8th bit, present the completed byte. If `rx_valid` is 0, or `rx_read` is in the same cycle, set `rx_data` to the byte and `rx_valid` to 1.
  - Otherwise drop the new byte, keep the old `rx_data`, and set `overrun`.
- SCK falling edge in SHIFT:
  - If `bit_cnt` is 0 (a byte boundary), reload the TX shift register exactly as on entry, including the underrun rule.
  - Otherwise shift the TX register left.
  - `spi_miso` follows bit 7 of the TX shift register.
- Synchronised CS rising edge, from any state: go to IDLE, discard any partial RX byte, clear `bit_cnt`, set `spi_miso_oe` to 0 and `spi_miso` to 1. The TX holding register is unaffected.
- TX holding register:
  - `tx_load` with `tx_empty`=1 stores the byte; `tx_empty` goes to 0 the next cycle.
  - `tx_load` with `tx_empty`=0 is ignored.
  - `tx_load` in the same cycle as a reload while empty: the reload sends 8'hFF with underrun, and the loaded byte is kept for the next reload.
- `rx_read` clears `rx_valid` unless a new byte lands in the same cycle; in that case `rx_valid` stays 1, `rx_data` updates, and there is no overrun.
- `clr_status` clears `overrun` and `underrun`. If a set condition occurs in the same cycle, the set wins.
- Reset values:
  - `spi_miso`=1, `spi_miso_oe`=0, `txn_active`=0.
  - `rx_data`=0, `rx_valid`=0, `tx_empty`=1, `overrun`=0, `underrun`=0.
  - State IDLE. The CS synchroniser resets to 0 and the SCK synchroniser to 0.
- Reset mid-transfer aborts immediately. Because the CS synchroniser resets to 0, a CS held low through reset starts no transaction; a new transfer needs a fresh CS high-to-low edge.

## Timing
- Pin-to-effect latency is `SYNC_STAGES`+1 `clk` cycles (3 at default) for each of:
  - CS fall to MISO valid.
  - SCK fall to MISO update.
  - 8th SCK rise to `rx_valid`.
- External requirements:
  - SCK high and low times each ≥ `SYNC_STAGES`+2 `clk` cycles, which gives f_SCK ≤ f_clk/8 at default.
  - CS fall to first SCK rise ≥ `SYNC_STAGES`+2 `clk` cycles.
  - MOSI stable across the synchronised sampling window; mode 0 guarantees this.
- `tx_empty` and `rx_valid` respond to `tx_load` and `rx_read` in one cycle.
- The CPU must reload TX within 8 SCK periods of `tx_empty` rising to avoid underrun.

## Structure
- Shared package/header `spi_pkg` holds:
  - The IDLE/SHIFT state encoding.
  - `SPI_FILL_BYTE` = 8'hFF.
- Sub-module `sync_ff`: depth-parametrised flop synchroniser with an explicit reset value, instantiated three times (CS, SCK, MOSI).
- The top of the design maps the RX/TX data and status registers into a new peripheral address slot.

## Test plan
- Load 8'hA5 with CS idle, then the controller sends 8'h3C in one transfer → MISO returns 8'hA5; `rx_data`=8'h3C and `rx_valid`=1 three cycles after the 8th SCK rise; `tx_empty`=1.
- Two-byte transfer, only 8'h11 loaded → second byte out is 8'hFF and `underrun`=1; `clr_status` → `underrun`=0.
- Receive 8'h01 then 8'h02 with no `rx_read` → `rx_data` stays 8'h01 and `overrun`=1. Repeat with `rx_read` coinciding with the 8th bit → `rx_data`=8'h02, `rx_valid`=1, `overrun`=0.
- CS deasserted after 5 bits → `rx_valid` unchanged, `spi_miso_oe`=0, `spi_miso`=1, state IDLE. The next full transfer receives its byte correctly.
- `rstn` asserted mid-byte with CS held low → all outputs at reset values. After release, no transfer happens until CS goes high then low.
- `tx_load` while `tx_empty`=0 → the original byte is transmitted and the new one is discarded.
